// File: rtl/fifo_pkg.sv
// Shared FIFO definitions: sizes plus state encodings for the read-side
// reader and the write-side address/control logic.
package fifo_pkg;

   localparam int FIFO_DEPTH = 8;
   localparam int CNT_WIDTH  = 4;
   localparam int DATA_WIDTH = 32;

   typedef enum logic [2:0] {
      RS_IDLE     = 3'd0,
      RS_REQ      = 3'd1,
      RS_CAPTURE  = 3'd2,
      RS_HOLD     = 3'd3,
      RS_DONE     = 3'd4,
      RS_RD_ERROR = 3'd5
   } rd_state_e;

   typedef enum logic [2:0] {
      WS_IDLE     = 3'd0,
      WS_WRITE    = 3'd1,
      WS_READ     = 3'd2,
      WS_WR_ERROR = 3'd3,
      WS_RD_ERROR = 3'd4
   } wr_state_e;

   // A burst is legal only if it fits the FIFO and the words are already there.
   function automatic logic len_ok(input logic [CNT_WIDTH-1:0] len,
                                   input logic [CNT_WIDTH-1:0] count);
      return !(len > CNT_WIDTH'(FIFO_DEPTH)) && !(len > count);
   endfunction

endpackage

// File: rtl/fifo_out_reader_if.sv
// Burst-request, FIFO-pop and downstream valid/ready signals of the reader.
interface fifo_out_reader_if #(
   parameter int DATA_WIDTH = 32,
   parameter int CNT_WIDTH  = 4
);
   logic                  rd_start;
   logic [CNT_WIDTH-1:0]  rd_len;
   logic [CNT_WIDTH-1:0]  fifo_data_count;
   logic                  fifo_empty;
   logic [DATA_WIDTH-1:0] fifo_dout;
   logic                  fifo_re;
   logic                  m_valid;
   logic                  m_ready;
   logic [DATA_WIDTH-1:0] m_data;
   logic                  busy;
   logic                  done;
   logic                  rd_error;

   modport slave (
      input  rd_start, rd_len, fifo_data_count, fifo_empty, fifo_dout, m_ready,
      output fifo_re, m_valid, m_data, busy, done, rd_error
   );

   modport master (
      output rd_start, rd_len, fifo_data_count, fifo_empty, fifo_dout, m_ready,
      input  fifo_re, m_valid, m_data, busy, done, rd_error
   );
endinterface

// File: rtl/fifo_out_ns.sv
// Combinational next-state / next-remaining logic and state-decoded strobes
// for the FIFO reader; holds no registers.
module fifo_out_ns
   import fifo_pkg::*;
#(
   parameter int CNT_WIDTH = fifo_pkg::CNT_WIDTH
) (
   input  rd_state_e            state_q_i,
   input  logic [CNT_WIDTH-1:0] remaining_q_i,
   input  logic                 rd_start_i,
   input  logic [CNT_WIDTH-1:0] rd_len_i,
   input  logic [CNT_WIDTH-1:0] fifo_data_count_i,
   input  logic                 fifo_empty_i,
   input  logic                 m_ready_i,
   output rd_state_e            state_d_o,
   output logic [CNT_WIDTH-1:0] remaining_d_o,
   output logic                 fifo_re_o,
   output logic                 busy_o,
   output logic                 done_o,
   output logic                 rd_error_o
);

   always_comb begin
      state_d_o     = state_q_i;
      remaining_d_o = remaining_q_i;
      case (state_q_i)
         RS_IDLE: begin
            if (rd_start_i) begin
               if (!len_ok(rd_len_i, fifo_data_count_i)) begin
                  state_d_o = RS_RD_ERROR;
               end else if (rd_len_i == '0) begin
                  state_d_o = RS_DONE;
               end else begin
                  remaining_d_o = rd_len_i;
                  state_d_o     = RS_REQ;
               end
            end
         end
         // An empty FIFO here aborts the burst without popping.
         RS_REQ:     state_d_o = fifo_empty_i ? RS_RD_ERROR : RS_CAPTURE;
         RS_CAPTURE: begin
            remaining_d_o = remaining_q_i - CNT_WIDTH'(1);
            state_d_o     = RS_HOLD;
         end
         RS_HOLD: begin
            if (m_ready_i) state_d_o = (remaining_q_i == '0) ? RS_DONE : RS_REQ;
         end
         RS_DONE:     state_d_o = RS_IDLE;
         RS_RD_ERROR: begin
            remaining_d_o = '0;
            state_d_o     = RS_IDLE;
         end
         default: begin
            remaining_d_o = '0;
            state_d_o     = RS_IDLE;
         end
      endcase
   end

   assign fifo_re_o  = (state_q_i == RS_REQ) && !fifo_empty_i;
   assign busy_o     = (state_q_i != RS_IDLE);
   assign done_o     = (state_q_i == RS_DONE);
   assign rd_error_o = (state_q_i == RS_RD_ERROR);

endmodule

// File: rtl/fifo_out_reader.sv
// Read-side FIFO controller: pops a burst one word at a time and presents
// each word on a valid/ready output, ending with a done or rd_error pulse.
module fifo_out_reader
   import fifo_pkg::*;
#(
   parameter int DATA_WIDTH = fifo_pkg::DATA_WIDTH,
   parameter int CNT_WIDTH  = fifo_pkg::CNT_WIDTH
) (
   input  logic               clk,
   input  logic               reset,
   fifo_out_reader_if.slave   bus
);

   rd_state_e             state_q, state_d;
   logic [CNT_WIDTH-1:0]  remaining_q, remaining_d;
   logic                  m_valid_q;
   logic [DATA_WIDTH-1:0] m_data_q;
   logic                  fifo_re, busy, done, rd_error;

   fifo_out_ns #(.CNT_WIDTH(CNT_WIDTH)) u_ns (
      .state_q_i         (state_q),
      .remaining_q_i     (remaining_q),
      .rd_start_i        (bus.rd_start),
      .rd_len_i          (bus.rd_len),
      .fifo_data_count_i (bus.fifo_data_count),
      .fifo_empty_i      (bus.fifo_empty),
      .m_ready_i         (bus.m_ready),
      .state_d_o         (state_d),
      .remaining_d_o     (remaining_d),
      .fifo_re_o         (fifo_re),
      .busy_o            (busy),
      .done_o            (done),
      .rd_error_o        (rd_error)
   );

   // Reset discards any word popped but not yet accepted downstream.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= RS_IDLE;
         remaining_q <= '0;
         m_valid_q   <= 1'b0;
         m_data_q    <= '0;
      end else begin
         state_q     <= state_d;
         remaining_q <= remaining_d;
         if (state_q == RS_CAPTURE) begin
            m_data_q  <= bus.fifo_dout;
            m_valid_q <= 1'b1;
         end else if (state_q == RS_HOLD && bus.m_ready) begin
            m_valid_q <= 1'b0;
         end
      end
   end

   assign bus.fifo_re  = fifo_re;
   assign bus.busy     = busy;
   assign bus.done     = done;
   assign bus.rd_error = rd_error;
   assign bus.m_valid  = m_valid_q;
   assign bus.m_data   = m_data_q;

endmodule

// File: tb/tb_fifo_out_reader.sv
// Directed bench for fifo_out_reader with a behavioural FIFO and a word scoreboard.
module tb_fifo_out_reader;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  fifo_out_reader_if #(.DATA_WIDTH(32), .CNT_WIDTH(4)) ifc ();

  fifo_out_reader dut (.clk(clk), .reset(reset), .bus(ifc));

  // behavioural FIFO storage
  logic        push_en = 1'b0, flush = 1'b0, force_empty = 1'b0, cnt_ovr_en = 1'b0;
  logic [31:0] push_data = '0;
  logic [3:0]  cnt_ovr = '0;
  logic [31:0] mem [8];
  logic [2:0]  head, tail;
  logic [3:0]  count;
  logic [31:0] dout;

  always @(posedge clk) begin
    if (flush) begin
      head <= '0; tail <= '0; count <= '0;
    end else begin
      if (ifc.fifo_re) begin dout <= mem[head]; head <= head + 3'd1; end
      if (push_en) begin mem[tail] <= push_data; tail <= tail + 3'd1; end
      count <= count + 4'(push_en) - 4'(ifc.fifo_re);
    end
  end

  assign ifc.fifo_dout       = dout;
  assign ifc.fifo_empty      = (count == 4'd0) | force_empty;
  assign ifc.fifo_data_count = cnt_ovr_en ? cnt_ovr : count;

  // monitor
  int cyc = 0, re_cnt = 0, done_cnt = 0, err_cnt = 0, mv_cnt = 0, acc_cyc = 0, done_cyc = 0;
  logic [31:0] obs_q[$];
  logic [31:0] exp_q[$];

  always @(negedge clk) begin
    cyc++;
    if (!reset) begin
      if (ifc.fifo_re) re_cnt++;
      if (ifc.done) begin done_cnt++; done_cyc = cyc; end
      if (ifc.rd_error) err_cnt++;
      if (ifc.m_valid) mv_cnt++;
      if (ifc.m_valid && ifc.m_ready) begin obs_q.push_back(ifc.m_data); acc_cyc = cyc; end
    end
  end

  int n_chk = 0, n_fail = 0;
  int re0, done0, err0, mv0, n;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_chk++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic push(input logic [31:0] d, input bit expect_out);
    push_en = 1'b1; push_data = d;
    step();
    push_en = 1'b0;
    if (expect_out) exp_q.push_back(d);
  endtask

  task automatic do_flush();
    flush = 1'b1; step(); flush = 1'b0;
  endtask

  task automatic start(input logic [3:0] len);
    ifc.rd_len = len; ifc.rd_start = 1'b1;
    step();
    ifc.rd_start = 1'b0;
  endtask

  task automatic snap();
    re0 = re_cnt; done0 = done_cnt; err0 = err_cnt; mv0 = mv_cnt;
  endtask

  task automatic wait_done(input string tag);
    n = 0;
    while (!ifc.done && n < 60) begin step(); n++; end
    chk(tag, 32'(ifc.done), 32'd1);
    step();
  endtask

  task automatic drain(input string tag);
    chk({tag, "_count"}, 32'(obs_q.size()), 32'(exp_q.size()));
    while (exp_q.size() > 0 && obs_q.size() > 0) chk(tag, obs_q.pop_front(), exp_q.pop_front());
    exp_q.delete(); obs_q.delete();
  endtask

  initial begin
    ifc.rd_start = 1'b0; ifc.rd_len = '0; ifc.m_ready = 1'b0;
    flush = 1'b1;
    step(); step();
    chk("rst_busy",     32'(ifc.busy),     32'd0);
    chk("rst_m_valid",  32'(ifc.m_valid),  32'd0);
    chk("rst_m_data",   ifc.m_data,        32'd0);
    chk("rst_done",     32'(ifc.done),     32'd0);
    chk("rst_rd_error", 32'(ifc.rd_error), 32'd0);
    chk("rst_fifo_re",  32'(ifc.fifo_re),  32'd0);
    flush = 1'b0; reset = 1'b0;
    step();

    // three-word burst, consumer always ready
    push(32'hA, 1'b1); push(32'hB, 1'b1); push(32'hC, 1'b1);
    ifc.m_ready = 1'b1;
    snap();
    start(4'd3);
    n = 1;
    while (!ifc.m_valid && n < 20) begin step(); n++; end
    chk("t1_first_valid_latency", 32'(n), 32'd3);
    wait_done("t1_done_seen");
    chk("t1_fifo_re_pulses", 32'(re_cnt - re0), 32'd3);
    chk("t1_done_pulses",    32'(done_cnt - done0), 32'd1);
    chk("t1_done_after_accept", 32'(done_cyc - acc_cyc), 32'd1);
    chk("t1_idle_after", 32'(ifc.busy), 32'd0);
    drain("t1_word");

    // back-pressure: output must hold, no further pop
    push(32'h11, 1'b1); push(32'h22, 1'b1);
    ifc.m_ready = 1'b0;
    snap();
    start(4'd2);
    n = 0;
    while (!ifc.m_valid && n < 20) begin step(); n++; end
    chk("t2_first_word", ifc.m_data, 32'h11);
    for (int i = 0; i < 5; i++) begin
      step();
      chk("t2_hold_valid", 32'(ifc.m_valid), 32'd1);
      chk("t2_hold_data",  ifc.m_data,       32'h11);
    end
    chk("t2_no_second_pop", 32'(re_cnt - re0), 32'd1);
    ifc.m_ready = 1'b1;
    wait_done("t2_done_seen");
    chk("t2_fifo_re_pulses", 32'(re_cnt - re0), 32'd2);
    chk("t2_last_word_kept", ifc.m_data, 32'h22);
    drain("t2_word");

    // length exceeds occupancy
    do_flush();
    push(32'h31, 1'b0); push(32'h32, 1'b0);
    snap();
    start(4'd4);
    chk("t3_rd_error", 32'(ifc.rd_error), 32'd1);
    step();
    chk("t3_rd_error_pulse", 32'(ifc.rd_error), 32'd0);
    chk("t3_idle", 32'(ifc.busy), 32'd0);
    chk("t3_err_pulses", 32'(err_cnt - err0), 32'd1);
    chk("t3_no_pop", 32'(re_cnt - re0), 32'd0);
    chk("t3_no_valid", 32'(mv_cnt - mv0), 32'd0);

    // zero-length burst
    snap();
    start(4'd0);
    chk("t4_done", 32'(ifc.done), 32'd1);
    step();
    chk("t4_done_pulse", 32'(ifc.done), 32'd0);
    chk("t4_done_pulses", 32'(done_cnt - done0), 32'd1);
    chk("t4_no_pop", 32'(re_cnt - re0), 32'd0);

    // length above depth even with large reported occupancy
    cnt_ovr_en = 1'b1; cnt_ovr = 4'd15;
    snap();
    start(4'd9);
    chk("t5_rd_error", 32'(ifc.rd_error), 32'd1);
    step();
    cnt_ovr_en = 1'b0;
    chk("t5_no_pop", 32'(re_cnt - re0), 32'd0);
    chk("t5_err_pulses", 32'(err_cnt - err0), 32'd1);

    // FIFO reports empty in REQ
    force_empty = 1'b1;
    snap();
    start(4'd1);
    chk("t6_req_busy", 32'(ifc.busy), 32'd1);
    chk("t6_req_no_pop", 32'(ifc.fifo_re), 32'd0);
    step();
    chk("t6_rd_error", 32'(ifc.rd_error), 32'd1);
    step();
    chk("t6_idle", 32'(ifc.busy), 32'd0);
    chk("t6_no_pop", 32'(re_cnt - re0), 32'd0);
    chk("t6_no_valid", 32'(mv_cnt - mv0), 32'd0);
    force_empty = 1'b0;

    // rd_start mid-burst is ignored
    do_flush();
    push(32'h71, 1'b1); push(32'h72, 1'b1); push(32'h73, 1'b0);
    ifc.m_ready = 1'b1;
    snap();
    start(4'd2);
    step();
    ifc.rd_start = 1'b1; ifc.rd_len = 4'd3;
    step(); step();
    ifc.rd_start = 1'b0;
    wait_done("t7_done_seen");
    chk("t7_fifo_re_pulses", 32'(re_cnt - re0), 32'd2);
    chk("t7_left_in_fifo", 32'(count), 32'd1);
    chk("t7_idle", 32'(ifc.busy), 32'd0);
    drain("t7_word");

    // reset while holding an unaccepted word
    do_flush();
    push(32'h1234, 1'b0);
    ifc.m_ready = 1'b0;
    start(4'd1);
    n = 0;
    while (!ifc.m_valid && n < 20) begin step(); n++; end
    chk("t8_hold_data", ifc.m_data, 32'h1234);
    #1 reset = 1'b1;
    #1;
    chk("t8_rst_m_valid", 32'(ifc.m_valid), 32'd0);
    chk("t8_rst_m_data",  ifc.m_data,       32'd0);
    chk("t8_rst_busy",    32'(ifc.busy),    32'd0);
    step();
    reset = 1'b0;
    step();
    chk("t8_idle_after", 32'(ifc.busy), 32'd0);
    chk("t8_no_valid_after", 32'(ifc.m_valid), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/fifo_out_reader.md
Name: fifo_out_reader

Overview:
- Read-side controller for the 8-entry FIFO; the counterpart of the write-side address/control logic.
- On a burst request it pops words from the FIFO memory one at a time and presents each word downstream on a valid/ready handshake.
- It ends every burst with a done pulse, or rejects the burst with an error pulse.
- Sits between the FIFO storage (head/data_count owner) and the consumer of results.

Parameters:
- DATA_WIDTH, 32, width of a FIFO word.
- CNT_WIDTH, 4, width of data_count and burst length (0..8 valid).

Ports:
- clk  input  1  system clock; all state changes on its rising edge.
- reset  input  1  asynchronous, active-high reset.
- rd_start  input  1  one-cycle burst request; sampled only in IDLE.
- rd_len  input  CNT_WIDTH  number of words to pop; sampled with rd_start.
- fifo_data_count  input  CNT_WIDTH  current FIFO occupancy.
- fifo_empty  input  1  FIFO empty flag.
- fifo_dout  input  DATA_WIDTH  FIFO read data; valid the cycle after fifo_re.
- fifo_re  output  1  FIFO pop strobe; FIFO increments head and decrements data_count.
- m_valid  output  1  m_data holds an unaccepted word.
- m_ready  input  1  consumer accepts when m_valid & m_ready.
- m_data  output  DATA_WIDTH  output word register.
- busy  output  1  high in every state except IDLE.
- done  output  1  one-cycle pulse at burst completion.
- rd_error  output  1  one-cycle pulse when a burst is rejected or aborted.

Behaviour:
- Reset: state=IDLE; remaining=0; m_valid=0; m_data=0; done=0; rd_error=0; fifo_re=0; busy=0.
- Reset mid-burst: same values immediately. A word already popped but not accepted is discarded.
- States: IDLE, REQ, CAPTURE, HOLD, DONE, RD_ERROR. State encoding belongs in the package.
- fifo_re=1 only in REQ and only when fifo_empty=0. It is decoded from the registered state, so no glitches.
- busy is decoded from state (state!=IDLE).
- done=1 only in DONE; rd_error=1 only in RD_ERROR.
- IDLE:
  - rd_start=0: stay in IDLE.
  - rd_start=1, rd_len>8 or rd_len>fifo_data_count: go to RD_ERROR.
  - rd_start=1, rd_len==0: go to DONE.
  - otherwise: remaining<=rd_len, go to REQ.
- REQ: if fifo_empty=1, go to RD_ERROR and drop the burst without popping. Otherwise pop one word and go to CAPTURE.
- CAPTURE: m_data<=fifo_dout, m_valid<=1, remaining<=remaining-1, go to HOLD.
- HOLD:
  - m_valid stays 1 and m_data is stable until m_ready=1.
  - On m_ready: m_valid<=0; go to DONE if remaining==0, else go to REQ.
- DONE: one cycle, then IDLE.
- RD_ERROR: one cycle, then IDLE. remaining<=0.
- rd_start outside IDLE is ignored; no queuing.
- Throughput: 3 cycles per word with m_ready held high (REQ, CAPTURE, HOLD).
- Latency from rd_start to first m_valid: 3 cycles.
- m_data keeps the last accepted word after the handshake until the next CAPTURE.
- Arithmetic: remaining is CNT_WIDTH unsigned. It never underflows, because CAPTURE is reached only with remaining>=1.
- Length comparisons are unsigned and full-width.
- Simultaneous fifo_empty falling and REQ entry: fifo_empty is sampled in REQ, so a pop occurs only if fifo_empty=0 in that cycle.
- The writer may push during a burst. Occupancy only grows from the writer side, so the length check made at start remains sufficient.

Decomposition:
- Shared package fifo_pkg: state encodings for this block, FIFO_DEPTH=8, CNT_WIDTH=4, DATA_WIDTH=32.
- The write-side FIFO state constants (IDLE/WRITE/READ/WR_ERROR/RD_ERROR) also move to fifo_pkg.
- Optional sub-module fifo_out_ns: combinational next-state, fifo_re, busy and next-remaining logic. Registers stay in fifo_out_reader.

Test Plan:
- Reset during HOLD with m_data=0x1234: asserting reset -> m_valid=0, m_data=0, busy=0 immediately; IDLE after release.
- fifo_data_count=3, rd_start with rd_len=3, m_ready=1, FIFO holds 0xA,0xB,0xC -> exactly 3 fifo_re pulses; m_data=0xA,0xB,0xC in order; done one cycle after the third accept; first m_valid 3 cycles after rd_start.
- rd_len=2, m_ready=0 for 5 cycles after first m_valid -> m_valid and m_data stable, no second fifo_re until m_ready=1.
- fifo_data_count=2, rd_len=4 -> rd_error pulse 1 cycle later, no fifo_re, no m_valid.
- rd_len=0 -> done pulse 1 cycle later, no fifo_re.
- rd_len=9 -> rd_error pulse, no fifo_re.
- fifo_empty forced high in REQ -> no fifo_re, rd_error pulse, return to IDLE.
- rd_start pulsed mid-burst -> ignored, burst word count unchanged.
